// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the pipeline writeback
//   path (priority) and queued MUL/DIV results. Queued results whose
//   destination is overwritten by a younger pipe write are killed and retired
//   silently. A starvation counter raises STALL_REQ so a live queue head is
//   guaranteed to retire.
// Ports
//   CLK, RESET          clock, asynchronous active-low reset
//   PIPE_WE/ADDR/DATA   pipeline writeback request
//   PIPE_ACCEPT         pipe write taken this cycle (comb)
//   STALL_REQ           pipeline must hold its WB instruction (registered)
//   MD_VALID/ADDR/DATA  MUL/DIV result, handshaken with MD_READY (comb)
//   RF_WRITE_*          registered register-file write port
//   PENDING_MASK        one bit per register targeted by a live queued entry (comb)
module regfile_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIPE_WE,
    input  logic [4:0]  PIPE_ADDR,
    input  logic [31:0] PIPE_DATA,
    output logic        PIPE_ACCEPT,
    output logic        STALL_REQ,
    input  logic        MD_VALID,
    output logic        MD_READY,
    input  logic [4:0]  MD_ADDR,
    input  logic [31:0] MD_DATA,
    output logic        RF_WRITE_ENABLE,
    output logic [4:0]  RF_WRITE_ADDRESS,
    output logic [31:0] RF_WRITE_DATA,
    output logic [31:0] PENDING_MASK
);

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } md_entry_t;

    md_entry_t             q_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] occ_q, occ_d;
    logic [FIFO_DEPTH-1:0] kill_q, kill_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic                  rf_we_q, rf_we_d;
    logic [AW-1:0]         rf_addr_q, rf_addr_d;
    logic [DW-1:0]         rf_data_q, rf_data_d;

    logic q_empty, q_full, head_live, pipe_grant, pop, push;

    // Handshake and grant decode
    assign q_empty     = ~|occ_q;
    assign q_full      = &occ_q;
    assign head_live   = occ_q[rd_ptr_q] & ~kill_q[rd_ptr_q];
    assign MD_READY    = RESET & ~q_full;
    assign PIPE_ACCEPT = RESET & PIPE_WE & ~stall_q;
    assign pipe_grant  = PIPE_ACCEPT;
    assign pop         = RESET & ~pipe_grant & ~q_empty;
    // x0 results are handshaken but never stored
    assign push        = MD_VALID & MD_READY & (MD_ADDR != '0);

    // Pending-destination mask over live queued entries
    always_comb begin
        PENDING_MASK = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (occ_q[i] && !kill_q[i]) begin
                PENDING_MASK[q_mem[i].addr] = 1'b1;
            end
        end
    end

    // Next-state: grant, queue bookkeeping, starvation guard
    always_comb begin
        occ_d     = occ_q;
        kill_d    = kill_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        starve_d  = starve_q;
        stall_d   = stall_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;

        if (pipe_grant) begin
            if (PIPE_ADDR != '0) begin
                rf_we_d   = 1'b1;
                rf_addr_d = PIPE_ADDR;
                rf_data_d = PIPE_DATA;
                // Older queued results to the same register are now stale
                for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                    if (occ_q[i] && (q_mem[i].addr == PIPE_ADDR)) begin
                        kill_d[i] = 1'b1;
                    end
                end
            end
        end else if (pop) begin
            if (head_live) begin
                rf_we_d   = 1'b1;
                rf_addr_d = q_mem[rd_ptr_q].addr;
                rf_data_d = q_mem[rd_ptr_q].data;
            end
            occ_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end

        // Same-cycle enqueue is younger than the pipe write: never killed
        if (push) begin
            occ_d[wr_ptr_q]  = 1'b1;
            kill_d[wr_ptr_q] = 1'b0;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        if (pop || q_empty) begin
            starve_d = '0;
        end else if (pipe_grant && head_live && (starve_q != CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + CNT_W'(1);
        end

        if (pop) begin
            stall_d = 1'b0;
        end else if (starve_d == CNT_W'(STARVE_LIMIT)) begin
            stall_d = 1'b1;
        end
    end

    // Control state
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            occ_q     <= '0;
            kill_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            occ_q     <= occ_d;
            kill_q    <= kill_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Queue payload storage; validity is tracked by occ_q
    always_ff @(posedge CLK) begin
        if (push) begin
            q_mem[wr_ptr_q] <= '{addr: MD_ADDR, data: MD_DATA};
        end
    end

    assign STALL_REQ        = stall_q;
    assign RF_WRITE_ENABLE  = rf_we_q;
    assign RF_WRITE_ADDRESS = rf_addr_q;
    assign RF_WRITE_DATA    = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Randomized and directed stimulus; expected register-file writes are pushed
//   to a scoreboard by a queue-based reference model and popped by a monitor.
module tb_regfile_wb_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PIPE_WE;
    logic [4:0]  PIPE_ADDR;
    logic [31:0] PIPE_DATA;
    logic        PIPE_ACCEPT;
    logic        STALL_REQ;
    logic        MD_VALID;
    logic        MD_READY;
    logic [4:0]  MD_ADDR;
    logic [31:0] MD_DATA;
    logic        RF_WRITE_ENABLE;
    logic [4:0]  RF_WRITE_ADDRESS;
    logic [31:0] RF_WRITE_DATA;
    logic [31:0] PENDING_MASK;

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .PIPE_WE(PIPE_WE), .PIPE_ADDR(PIPE_ADDR), .PIPE_DATA(PIPE_DATA),
        .PIPE_ACCEPT(PIPE_ACCEPT), .STALL_REQ(STALL_REQ),
        .MD_VALID(MD_VALID), .MD_READY(MD_READY), .MD_ADDR(MD_ADDR), .MD_DATA(MD_DATA),
        .RF_WRITE_ENABLE(RF_WRITE_ENABLE), .RF_WRITE_ADDRESS(RF_WRITE_ADDRESS),
        .RF_WRITE_DATA(RF_WRITE_DATA), .PENDING_MASK(PENDING_MASK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          killed;
    } ent_t;

    ent_t        m_q[$];
    logic [36:0] sb[$];
    bit          m_stall;
    int          m_starve;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (m_q[i]) if (!m_q[i].killed) m[m_q[i].addr] = 1'b1;
        return m;
    endfunction

    // One cycle of the reference model, from the arbitration rules
    task automatic model_cycle(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bit   ready   = (m_q.size() < DEPTH);
        bit   accept  = pw && !m_stall;
        bit   was_empty = (m_q.size() == 0);
        bit   live    = !was_empty && !m_q[0].killed;
        bit   popped  = 0;
        ent_t e;
        if (accept) begin
            if (pa != 0) begin
                sb.push_back({pa, pd});
                foreach (m_q[i]) if (m_q[i].addr == pa) begin
                    e = m_q[i]; e.killed = 1; m_q[i] = e;
                end
            end
        end else if (!was_empty) begin
            e = m_q.pop_front();
            if (!e.killed) sb.push_back({e.addr, e.data});
            popped = 1;
        end
        if (mv && ready && ma != 0) begin
            e.addr = ma; e.data = md; e.killed = 0;
            m_q.push_back(e);
        end
        if (popped || was_empty) m_starve = 0;
        else if (accept && live && m_starve < LIMIT) m_starve++;
        if (popped) m_stall = 0;
        else if (m_starve == LIMIT) m_stall = 1;
    endtask

    task automatic step(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        @(negedge CLK);
        check("writes_retired", 64'(sb.size()), 64'd0);
        PIPE_WE = pw; PIPE_ADDR = pa; PIPE_DATA = pd;
        MD_VALID = mv; MD_ADDR = ma; MD_DATA = md;
        #1;
        check("md_ready", MD_READY, (m_q.size() < DEPTH));
        check("pipe_accept", PIPE_ACCEPT, pw && !m_stall);
        check("stall_req", STALL_REQ, m_stall);
        check("pending_mask", PENDING_MASK, model_mask());
        model_cycle(pw, pa, pd, mv, ma, md);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_stall", STALL_REQ, 0);
        check("rst_we", RF_WRITE_ENABLE, 0);
        check("rst_addr", RF_WRITE_ADDRESS, 0);
        check("rst_data", RF_WRITE_DATA, 0);
        check("rst_mask", PENDING_MASK, 0);
        check("rst_md_ready", MD_READY, 0);
        check("rst_accept", PIPE_ACCEPT, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1 check_reset_outputs();
        PIPE_WE = 0; MD_VALID = 0;
        m_q.delete(); sb.delete(); m_stall = 0; m_starve = 0;
        @(negedge CLK);
        check_reset_outputs();
        RESET = 1'b1;
    endtask

    // Monitor: every RF write must match the oldest expected write
    always @(posedge CLK) begin
        #1;
        if (RESET && RF_WRITE_ENABLE) begin
            check("rf_addr_nonzero", 64'(RF_WRITE_ADDRESS != 0), 64'd1);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL rf_unexpected: got addr %0d data 0x%0h expected no write at %0t",
                         RF_WRITE_ADDRESS, RF_WRITE_DATA, $time);
            end else begin
                check("rf_write", {RF_WRITE_ADDRESS, RF_WRITE_DATA}, sb.pop_front());
            end
        end
    end

    initial begin
        RESET = 1'b0; PIPE_WE = 0; PIPE_ADDR = 0; PIPE_DATA = 0;
        MD_VALID = 0; MD_ADDR = 0; MD_DATA = 0;
        m_stall = 0; m_starve = 0;
        #1 check_reset_outputs();
        @(negedge CLK) RESET = 1'b1;

        // MD result alone: written two edges after the handshake
        step(0, 5'd0, 32'd0, 1, 5'd5, 32'h42);
        idle(3);

        // Queue filled under continuous pipe traffic until STALL_REQ
        step(1, 5'd10, 32'h100, 1, 5'd3, 32'h300);
        step(1, 5'd11, 32'h101, 1, 5'd4, 32'h400);
        for (int i = 0; i < 8; i++) step(1, 5'(12 + i), 32'h200 + 32'(i), 1, 5'd6, 32'h666);
        idle(4);

        // WAW kill of a queued result
        step(0, 5'd0, 32'd0, 1, 5'd7, 32'hAAAA);
        step(1, 5'd7, 32'hBBBB, 0, 5'd0, 32'd0);
        idle(3);

        // x0 on both paths
        step(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
        idle(2);

        // Reset while two entries are queued and STALL_REQ is set
        step(1, 5'd20, 32'h1, 1, 5'd21, 32'h2);
        step(1, 5'd22, 32'h3, 1, 5'd23, 32'h4);
        step(1, 5'd24, 32'h5, 0, 5'd0, 32'd0);
        step(1, 5'd25, 32'h6, 0, 5'd0, 32'd0);
        step(1, 5'd26, 32'h7, 0, 5'd0, 32'd0);
        check("stall_before_reset", 64'(m_stall), 64'd1);
        do_reset();
        idle(4);

        // Same-cycle pipe write and MD enqueue to x9
        step(1, 5'd9, 32'h9999, 1, 5'd9, 32'h1234);
        idle(3);

        // Randomized traffic over a small register window to provoke kills
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 60), 5'($urandom_range(1, 7)), $urandom,
                 ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        idle(6);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
